rom: RTL and testbench

ROM -- requirements
Module: rom

---
 rtl/rom.sv | 82 ++++++++
 tb/tb_rom.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rom.sv
// ---------------------------------------------------------------------------
// rom -- 16 x 4-bit read-only memory with a registered, one-cycle read port.
//
// Contents are fixed at build time: word[a] = (3*a + 1) mod 16.
// No write path exists.
//
// Ports
//   clk       in   1  sole clock, rising-edge
//   rst_n     in   1  synchronous active-low reset (clears data and data_vld)
//   en        in   1  read enable, sampled on rising edge
//   addr      in   4  word address, sampled when en=1
//   data      out  4  registered read data
//   data_vld  out  1  high for the cycle after an enabled read
//
// Build option
//   ROM_CLR_ON_DIS_EN  when defined, an edge with en=0 clears data to 0;
//                      when undefined (default), data holds its last value.
//                      data_vld behaves the same in both builds.
// ---------------------------------------------------------------------------
module rom (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] addr,
    output logic [3:0] data,
    output logic       data_vld
);

    logic [3:0] r_data;
    logic       r_data_vld;
    logic [3:0] w_rom_word;

    // Fixed contents, written out as a table so they map to a plain lookup.
    function automatic logic [3:0] rom_lookup(input logic [3:0] a);
        logic [3:0] word;
        case (a)
            4'h0: word = 4'h1;
            4'h1: word = 4'h4;
            4'h2: word = 4'h7;
            4'h3: word = 4'hA;
            4'h4: word = 4'hD;
            4'h5: word = 4'h0;
            4'h6: word = 4'h3;
            4'h7: word = 4'h6;
            4'h8: word = 4'h9;
            4'h9: word = 4'hC;
            4'hA: word = 4'hF;
            4'hB: word = 4'h2;
            4'hC: word = 4'h5;
            4'hD: word = 4'h8;
            4'hE: word = 4'hB;
            default: word = 4'hE;
        endcase
        return word;
    endfunction

    assign w_rom_word = rom_lookup(addr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data     <= 4'h0;
            r_data_vld <= 1'b0;
        end else begin
            // Valid simply follows the sampled enable; it never looks at addr.
            r_data_vld <= en;
            if (en) begin
                r_data <= w_rom_word;
            end else begin
`ifdef ROM_CLR_ON_DIS_EN
                r_data <= 4'h0;
`else
                r_data <= r_data;
`endif
            end
        end
    end

    // Outputs come straight from flops.
    assign data     = r_data;
    assign data_vld = r_data_vld;

endmodule

// File: tb/tb_rom.sv
// ---------------------------------------------------------------------------
// tb_rom -- self-checking bench for rom: directed vector table, hand-written
// reset sequences, full address sweep and randomized traffic against a
// behavioural model.
// ---------------------------------------------------------------------------
module tb_rom;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] addr;
    logic [3:0] data;
    logic       data_vld;

    int n_checks;
    int n_fail;

    // Behavioural model state: what data/data_vld must show after each edge.
    logic [3:0] m_data;
    logic       m_vld;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [3:0] addr;
        logic [3:0] exp_data;
        logic       exp_vld;
    } vec_t;

    vec_t vecs[8];

    logic [3:0] rom_tbl[16];
    logic [3:0] dis_data;

    rom dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .addr     (addr),
        .data     (data),
        .data_vld (data_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of inputs for one rising edge, update the model, and
    // return #1 after the edge so outputs can be sampled.
    task automatic step(input logic r, input logic e, input logic [3:0] a);
        @(negedge clk);
        rst_n = r;
        en    = e;
        addr  = a;
        @(posedge clk);
        if (!r) begin
            m_data = 4'h0;
            m_vld  = 1'b0;
        end else begin
            m_vld = e;
            if (e) begin
                m_data = 4'((3 * int'(a) + 1) % 16);
            end else begin
`ifdef ROM_CLR_ON_DIS_EN
                m_data = 4'h0;
`endif
            end
        end
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] ed, input logic ev);
        n_checks++;
        if (data !== ed || data_vld !== ev) begin
            n_fail++;
            $display("FAIL %s: got data=%h vld=%b, expected data=%h vld=%b",
                     name, data, data_vld, ed, ev);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_data   = 4'h0;
        m_vld    = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b0;
        addr     = 4'h0;

        rom_tbl = '{4'h1, 4'h4, 4'h7, 4'hA, 4'hD, 4'h0, 4'h3, 4'h6,
                    4'h9, 4'hC, 4'hF, 4'h2, 4'h5, 4'h8, 4'hB, 4'hE};
`ifdef ROM_CLR_ON_DIS_EN
        dis_data = 4'h0;
`else
        dis_data = 4'hA;
`endif

        // Reset with en held high, release, sequential reads, disable, re-enable.
        vecs[0] = '{1'b0, 1'b1, 4'hA, 4'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 4'hA, 4'h0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 4'hA, 4'hF, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 4'h6, 4'h3, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 4'h3, 4'hA, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 4'hF, dis_data, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 4'h8, 4'h9, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 4'h0, 4'h1, 1'b1};

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].addr);
            check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_vld);
        end

        // Full sweep, one new word per edge.
        for (int a = 0; a < 16; a++) begin
            step(1'b1, 1'b1, 4'(a));
            check($sformatf("sweep%0d", a), rom_tbl[a], 1'b1);
        end

        // Mid-stream reset: stream 4,5, reset during 6, resume at 7.
        step(1'b1, 1'b1, 4'h4); check("mid_pre4", 4'hD, 1'b1);
        step(1'b1, 1'b1, 4'h5); check("mid_pre5", 4'h0, 1'b1);
        step(1'b0, 1'b1, 4'h6); check("mid_rst",  4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h7); check("mid_post", 4'h6, 1'b1);

        // Address wiggle while disabled must not disturb outputs.
        step(1'b1, 1'b0, 4'h2); check("idle_a", dis_data == 4'h0 ? 4'h0 : 4'h6, 1'b0);
        step(1'b1, 1'b0, 4'hC); check("idle_b", dis_data == 4'h0 ? 4'h0 : 4'h6, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            logic r, e;
            logic [3:0] a;
            r = ($urandom_range(0, 19) != 0);
            e = ($urandom_range(0, 3) != 0);
            a = 4'($urandom_range(0, 15));
            step(r, e, a);
            check($sformatf("rand%0d", i), m_data, m_vld);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
